uart_rx_fifo: RTL

Serial receive front-end of the Risco_5 SoC UART peripheral. Converts the asynchronous `rx` pin into 8N1 bytes and stores them in a receive FIFO of `BUFFER_SIZE` entries. The SoC bus-side UART register logic drains the FIFO through a show-ahead read port. Framing errors and overruns are reported as sticky flags.

---
 rtl/uart_pkg.sv | 19 +
 rtl/fifo.sv | 53 +++++
 rtl/uart_rx_fifo.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, receiver states and baud divisor helper.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  // Integer clock cycles per bit; the fractional part is truncated.
  function automatic int clks_per_bit(input int clock_freq, input int bit_rate);
    return clock_freq / bit_rate;
  endfunction

endpackage

// File: rtl/fifo.sv
// Show-ahead circular FIFO. Pointers carry one extra wrap bit so full and empty
// can be told apart without a separate occupancy register.
module fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW-1:0] == rptr[AW-1:0]) && (wptr[AW] != rptr[AW]);
  assign count = wptr - rptr;

  // A pop frees a slot in the same cycle, so a push into a full FIFO is
  // still accepted when it coincides with a pop.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  // Pointer advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  // Storage write; contents need no reset since empty masks the read port.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART 8N1 receiver feeding a show-ahead receive FIFO, with sticky framing
// error and overrun flags.
//
//   state | meaning
//   IDLE  | waiting for a falling edge on the synchronized line (once armed)
//   START | counting to mid start bit; line must still be low
//   DATA  | sampling 8 data bits at bit centres, LSB first
//   STOP  | sampling the stop bit; push on high, framing error on low
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ  = 25000000,
  parameter int BIT_RATE    = 115200,
  parameter int BUFFER_SIZE = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           rx,
  input  logic                           read_en,
  input  logic                           error_clear,
  output logic [7:0]                     read_data,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(BUFFER_SIZE):0]   count,
  output logic                           frame_error,
  output logic                           overrun
);

  localparam int CPB   = clks_per_bit(CLOCK_FREQ, BIT_RATE);
  localparam int CNT_W = $clog2(CPB);
  localparam int BIT_W = $clog2(DATA_BITS);

  // Terminal count is reached load+1 cycles after loading, so loads are one less.
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CPB / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CPB - 1);

  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic                 armed_q;
  logic                 fall;

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tc;
  logic                 push;
  logic                 ferr_set;
  logic                 ovr_set;

  // Synchronizer and edge history; reset to low so a line held low through
  // reset is never mistaken for a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      armed_q <= armed_q | rx_sync;
    end
  end

  assign fall = armed_q & rx_prev & ~rx_sync;
  assign tc   = (cnt_q == '0);

  // Receiver state, baud down-counter, bit index and shift register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state logic; the counter free-runs down to zero and holds there.
  always_comb begin
    state_d  = state_q;
    cnt_d    = tc ? cnt_q : cnt_q - CNT_W'(1);
    bit_d    = bit_q;
    shift_d  = shift_q;
    push     = 1'b0;
    ferr_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (fall) begin
          state_d = START;
          cnt_d   = HALF_LOAD;
          bit_d   = '0;
        end
      end
      START: begin
        if (tc) begin
          if (rx_sync) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cnt_d   = BIT_LOAD;
          end
        end
      end
      DATA: begin
        if (tc) begin
          shift_d = {rx_sync, shift_q[DATA_BITS-1:1]};
          cnt_d   = BIT_LOAD;
          if (bit_q == BIT_W'(DATA_BITS - 1)) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (tc) begin
          if (!rx_sync) begin
            ferr_set = 1'b1;
            state_d  = IDLE;
          end else if (bit_q == BIT_W'(STOP_BITS - 1)) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BIT_W'(1);
            cnt_d = BIT_LOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A full FIFO only rejects the byte when nothing is popped in the same cycle.
  assign ovr_set = push & full & ~read_en;

  // Sticky error flags; a new event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= ferr_set | (frame_error & ~error_clear);
      overrun     <= ovr_set  | (overrun & ~error_clear);
    end
  end

  fifo #(
    .DEPTH(BUFFER_SIZE),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (read_en),
    .wdata(shift_q),
    .rdata(read_data),
    .empty(empty),
    .full (full),
    .count(count)
  );

endmodule
